alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Command-side initiator for the 8-bit multi-cycle ALU. It accepts {op, A, B} commands on a valid/ready port and buffers them in a small FIFO. It issues each command to the ALU with a one-cycle `start` pulse, holds operands stable until `done`, and returns the 16-bit result in order on a valid/ready response port. NOP commands complete locally, and a timeout guards against an ALU that never answers.

## Interface
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 8, maximum cycles spent in `D_WAIT` before abandoning a command; ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full; a transfer occurs when `cmd_valid && cmd_ready` at an edge.
- `cmd_op`  in  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101–111 undefined.
- `cmd_a`, `cmd_b`  in  8  operands.
- `alu_start`  out  1  one-cycle start pulse to the ALU.
- `alu_a`, `alu_b`  out  8  operands to the ALU; held from `start` through `done`.
- `alu_op`  out  3  opcode to the ALU; held with the operands.
- `alu_result`  in  16  ALU result; valid while `alu_done`.
- `alu_done`  in  1  ALU completion, one cycle wide.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  16  result (0 for NOP or timeout).
- `rsp_op`  out  3  opcode of the completed command.
- `rsp_timeout`  out  1  command abandoned after `TIMEOUT`.
- `busy`  out  1  FIFO non-empty or FSM not in `D_IDLE`.

## Operation
- **FIFO**
  - Occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
  - `cmd_ready = !full`. There is no bypass when full.
  - A push and a pop in the same cycle leave the count unchanged.
- **`D_IDLE`**
  - If the FIFO is non-empty, pop the head into the holding registers.
  - If the popped op is 000, go to `D_RESP` with result 0 and timeout 0. The ALU is never started.
  - Otherwise go to `D_ISSUE`.
- **`D_ISSUE`**
  - `alu_start=1` for exactly this cycle. `alu_a`, `alu_b`, `alu_op` are driven from the holding registers.
  - Clear the timer, then go to `D_WAIT`.
- **`D_WAIT`**
  - On `alu_done=1`: capture `alu_result` into `rsp_result`, set `rsp_timeout=0`, go to `D_RESP`.
  - Otherwise increment the timer. When it reaches `TIMEOUT-1`, set `rsp_result=0`, `rsp_timeout=1`, and go to `D_RESP`.
  - `alu_done` is ignored in every other state.
- **`D_RESP`**
  - `rsp_valid=1`. `rsp_result`, `rsp_op`, `rsp_timeout` stay stable until `rsp_ready`.
  - On the handshake edge, go to `D_IDLE`.
- **Holding registers and ALU outputs**
  - `alu_a`, `alu_b`, `alu_op` change only on a pop. They are therefore stable through the ALU's result state, where the ALU reads them.
- **Opcodes and widths**
  - Undefined ops 101–111 are issued normally; the ALU returns `done` with result 0.
  - Result width is 16 bits. ADD carry appears in bit 8; the MUL result uses the full 16 bits.
- **Ordering**
  - Responses are strictly in command order. Capacity is `FIFO_DEPTH` queued commands plus 1 in flight.
- **Reset**
  - While `reset_n` is low: FSM in `D_IDLE`, FIFO empty, timer 0.
  - All outputs are 0 except `cmd_ready`, which is 1.
  - Reset mid-command drops the in-flight and queued commands; no response is produced. The ALU shares `reset_n`, so both sides return to idle together.

## Timing
- Latencies are counted in rising edges from the command-accept edge E0 until `rsp_valid` is high: NOP 1, ADD/AND/XOR/undefined 3, MUL 6.
- `alu_start` rises after E1 and falls after E2.
- Back-to-back non-MUL commands with `rsp_ready=1` give one response every 4 cycles; MUL gives one every 7.
- A response becomes visible at least one edge after `alu_done` (registered).
- Timeout response: `rsp_valid` rises `TIMEOUT` edges after entering `D_WAIT`.
- `cmd_ready` reflects the registered count. It falls on the edge that makes the FIFO full.

## Test plan
- ADD A=200, B=100, `rsp_ready=1` -> `rsp_result=0x012C`, `rsp_op=001`, `rsp_timeout=0`, `rsp_valid` 3 edges after accept, exactly one `alu_start` pulse.
- MUL A=255, B=255 -> `rsp_result=0xFE01`, 6 edges after accept; `alu_a`/`alu_b`/`alu_op` unchanged from `start` through `done`.
- NOP A=5, B=7 -> `rsp_result=0`, `rsp_op=000`, `rsp_valid` 1 edge after accept, `alu_start` never asserted.
- `rsp_ready=0`, offer 6 commands (ADD 1+1 … 6+6) -> exactly 5 accepted, `cmd_ready=0`. Raise `rsp_ready` -> results 2, 4, 6, 8, 10 in order, each stable while stalled. The 6th is then accepted and returns 12.
- `alu_done` tied low, ADD 3+4 -> `rsp_timeout=1` and `rsp_result=0` after `TIMEOUT`=8 edges in `D_WAIT`. The next command proceeds normally.
- Reset asserted 2 cycles into a MUL with 2 more queued -> no `rsp_valid`, `busy=0`, `cmd_ready=1`, `alu_start=0`. A new ADD 9+9 after release returns 0x0012.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 8-bit multi-cycle ALU: FIFO-buffered commands,
// start/done handshake with timeout, in-order responses.
module alu_cmd_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // state   | meaning
  // D_IDLE  | pop the next command when the FIFO holds one
  // D_ISSUE | one-cycle alu_start, timer cleared
  // D_WAIT  | waiting for alu_done or timer expiry
  // D_RESP  | response held until rsp_ready
  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2,
    D_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [18:0]     fifo_mem_q [FIFO_DEPTH];
  logic [2:0]      op_q;
  logic [7:0]      a_q, b_q;
  logic [15:0]     result_q, result_d;
  logic            tmo_q, tmo_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push, pop;
  logic [18:0]     head;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    pop      = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head[18:16] == 3'b000) begin
            state_d  = D_RESP;
            result_d = 16'h0000;
            tmo_d    = 1'b0;
          end else begin
            state_d = D_ISSUE;
          end
        end
      end
      D_ISSUE: begin
        timer_d = '0;
        state_d = D_WAIT;
      end
      D_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          tmo_d    = 1'b0;
          state_d  = D_RESP;
        end else if (timer_q == TMO_LAST) begin
          result_d = 16'h0000;
          tmo_d    = 1'b1;
          state_d  = D_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      D_RESP: begin
        if (rsp_ready) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= D_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      op_q     <= 3'b000;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 16'h0000;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
      timer_q  <= timer_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        op_q     <= head[18:16];
        a_q      <= head[15:8];
        b_q      <= head[7:0];
      end
    end
  end

  assign alu_start   = (state_q == D_ISSUE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp_valid   = (state_q == D_RESP);
  assign rsp_result  = result_q;
  assign rsp_op      = op_q;
  assign rsp_timeout = tmo_q;
  assign busy        = (count_q != '0) || (state_q != D_IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU (1-cycle ops, 4-cycle MUL).
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_a = 8'd0, cmd_b = 8'd0;
  logic        alu_start;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int acc = 0;
  int starts = 0;
  int base;
  int lat;
  int st0;
  logic rdy;
  logic sawv;
  logic feeding = 1'b0;
  logic alu_en = 1'b1;
  logic hold_err = 1'b0;
  int   alu_cnt;
  logic [7:0] ha, hb;
  logic [2:0] hop;

  alu_cmd_driver #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: done one edge after start, MUL three edges later; operands checked for stability.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_done   <= 1'b0;
      alu_result <= 16'h0000;
      alu_cnt    <= 0;
    end else begin
      alu_done <= 1'b0;
      if (alu_start && alu_en) begin
        ha <= alu_a; hb <= alu_b; hop <= alu_op;
        if (alu_op == 3'd4) begin
          alu_cnt <= 3;
        end else begin
          alu_done   <= 1'b1;
          alu_result <= alu_f(alu_op, alu_a, alu_b);
        end
      end else if (alu_cnt != 0) begin
        if (alu_a != ha || alu_b != hb || alu_op != hop) hold_err <= 1'b1;
        alu_cnt <= alu_cnt - 1;
        if (alu_cnt == 1) begin
          alu_done   <= 1'b1;
          alu_result <= alu_f(alu_op, alu_a, alu_b);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) acc <= acc + 1;
    if (reset_n && alu_start) starts <= starts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; while feeding, offer ADD n+n for n = 1..6.
  task automatic tick();
    int nxt;
    @(negedge clk);
    if (feeding) begin
      nxt = acc - base + 1;
      if (nxt <= 6) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_a     = 8'(nxt);
        cmd_b     = 8'(nxt);
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(rdy), 32'd1);
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    while (!rsp_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {alu_start, rsp_valid, rsp_timeout, busy, alu_a, alu_b, alu_op},
          32'd0);
    check("rst_rsp", {rsp_result, 13'd0, rsp_op}, 32'd0);
    reset_n = 1'b1;

    // ADD 200+100
    st0 = starts;
    send(3'd1, 8'd200, 8'd100);
    wait_rsp(lat);
    check("add_latency", lat, 3);
    check("add_result", rsp_result, 32'h012C);
    check("add_op", rsp_op, 3'd1);
    check("add_timeout", rsp_timeout, 0);
    tick();
    check("add_start_pulses", starts - st0, 1);
    check("add_rsp_cleared", rsp_valid, 0);

    // MUL 255*255
    send(3'd4, 8'd255, 8'd255);
    wait_rsp(lat);
    check("mul_latency", lat, 6);
    check("mul_result", rsp_result, 32'hFE01);
    check("mul_op", rsp_op, 3'd4);
    check("mul_operand_hold", hold_err, 0);
    tick();

    // NOP completes locally
    st0 = starts;
    send(3'd0, 8'd5, 8'd7);
    wait_rsp(lat);
    check("nop_latency", lat, 1);
    check("nop_result", rsp_result, 0);
    check("nop_op", rsp_op, 0);
    tick();
    check("nop_no_start", starts - st0, 0);

    // XOR and undefined op
    send(3'd3, 8'hA5, 8'h0F);
    wait_rsp(lat);
    check("xor_latency", lat, 3);
    check("xor_result", rsp_result, 32'h00AA);
    tick();
    send(3'd6, 8'h12, 8'h34);
    wait_rsp(lat);
    check("undef_latency", lat, 3);
    check("undef_result", rsp_result, 0);
    check("undef_op", rsp_op, 3'd6);
    tick();

    // Back-pressure: 4 queued + 1 in flight, then in-order drain
    rsp_ready = 1'b0;
    base = acc;
    feeding = 1'b1;
    repeat (12) tick();
    check("full_accepted", acc - base, 5);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    for (int k = 1; k <= 6; k++) begin
      wait_rsp(lat);
      check("drain_valid", rsp_valid, 1);
      check("drain_result", rsp_result, 32'(2 * k));
      tick();
      tick();
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, 32'(2 * k));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    feeding = 1'b0;
    cmd_valid = 1'b0;
    check("drain_total_accepted", acc - base, 6);
    rsp_ready = 1'b1;
    tick();
    check("drain_idle", busy, 0);

    // Timeout with a silent ALU, then normal recovery
    alu_en = 1'b0;
    send(3'd1, 8'd3, 8'd4);
    wait_rsp(lat);
    check("tmo_latency", lat, 10);
    check("tmo_flag", rsp_timeout, 1);
    check("tmo_result", rsp_result, 0);
    tick();
    alu_en = 1'b1;
    send(3'd1, 8'd10, 8'd20);
    wait_rsp(lat);
    check("post_tmo_latency", lat, 3);
    check("post_tmo_result", rsp_result, 32'd30);
    check("post_tmo_flag", rsp_timeout, 0);
    tick();

    // Reset in the middle of a MUL with two commands queued
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'd7; cmd_b = 8'd8;
    @(negedge clk);
    cmd_op = 3'd1; cmd_a = 8'd1; cmd_b = 8'd1;
    @(negedge clk);
    cmd_a = 8'd2; cmd_b = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    check("rstmid_alu_start", alu_start, 0);
    tick();
    tick();
    reset_n = 1'b1;
    sawv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) sawv = 1'b1;
    end
    check("rstmid_no_rsp", sawv, 0);
    send(3'd1, 8'd9, 8'd9);
    wait_rsp(lat);
    check("rstmid_add_latency", lat, 3);
    check("rstmid_add_result", rsp_result, 32'h0012);
    tick();
    check("final_hold", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
